dtc_cmd_sched: RTL and testbench

//  N-channel DTC command scheduler; sits between trigger/DCS command sources and per-port DTC serialisers.

---
 rtl/dtc_cmd_sched.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_dtc_cmd_sched.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_cmd_sched.sv
// DTC command scheduler: merges trigger, abort, readout, fast and slow commands into one arbitrated word bus.
// Optional statistics counters are enabled with `define DTC_CMD_SCHED_STATS_EN.
module dtc_cmd_sched #(
   parameter int              NCH     = 8,
   parameter int              TO_W    = 16,
   parameter logic [TO_W-1:0] TIMEOUT = 16'd4000
) (
   input  logic            gclk_40m,
   input  logic            reset_n,
   input  logic [NCH-1:0]  ch_mask,
   input  logic            fee_trig,
   input  logic            abortcmd,
   input  logic            rdocmd,
   input  logic            FastCmd,
   input  logic [7:0]      FastCmdCode,
   output logic            FastCmdAck,
   input  logic            cmd_dv,
   input  logic [31:0]     cmd_addr,
   input  logic [31:0]     cmd_data,
   output logic            cmd_dv_ack,
   output logic            cmd_err,
   input  logic [NCH-1:0]  tx_busy,
   input  logic [NCH-1:0]  reply_dv,
   output logic            tx_stb,
   output logic [NCH-1:0]  tx_sel,
   output logic [2:0]      tx_type,
   output logic [63:0]     tx_payload,
   output logic [NCH-1:0]  to_err,
   output logic [7:0]      trig_drop_cnt,
   input  logic            err_clr,
   output logic [15:0]     trig_cnt,
   output logic [15:0]     slow_cnt
);

   localparam logic [2:0] TYPE_TRIG  = 3'd1;
   localparam logic [2:0] TYPE_ABORT = 3'd2;
   localparam logic [2:0] TYPE_RDO   = 3'd3;
   localparam logic [2:0] TYPE_FAST  = 3'd4;
   localparam logic [2:0] TYPE_SLOW  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CHECK   = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_ACK     = 3'd4,
      S_RELEASE = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       cmd_addr_q, cmd_addr_d;
   logic [31:0]       cmd_data_q, cmd_data_d;
   logic [NCH-1:0]    targets_q, targets_d;
   logic [NCH-1:0]    replied_q, replied_d;
   logic [TO_W-1:0]   timer_q, timer_d;

   logic              trig_pend_q, trig_pend_d;
   logic              abort_pend_q, abort_pend_d;
   logic              rdo_pend_q, rdo_pend_d;
   logic              fast_pend_q, fast_pend_d;
   logic [7:0]        fast_code_q, fast_code_d;
   logic              fast_prev_q;

   logic              tx_stb_q, tx_stb_d;
   logic [NCH-1:0]    tx_sel_q, tx_sel_d;
   logic [2:0]        tx_type_q, tx_type_d;
   logic [63:0]       tx_payload_q, tx_payload_d;
   logic              fast_ack_q, fast_ack_d;
   logic              cmd_dv_ack_q, cmd_err_q;
   logic [NCH-1:0]    to_err_q, to_err_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;

   logic              bcast_ok_s, any_ch_s;
   logic              trig_take_s, abort_take_s, rdo_take_s, fast_take_s, slow_grant_s;
   logic              fast_rise_s, drop_s;
   logic [NCH-1:0]    chan_oh_s, targets_s, replied_now_s, to_set_s;
   logic              bad_s, all_replied_s, timeout_s;
   logic              slow_req_s, ack_set_s, err_set_s;

   assign bcast_ok_s  = ((tx_busy & ch_mask) == {NCH{1'b0}});
   assign any_ch_s    = (ch_mask != {NCH{1'b0}});
   assign fast_rise_s = FastCmd & ~fast_prev_q;

   // Slow-command target decode from the captured address
   always_comb begin
      chan_oh_s = {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         if (int'(cmd_addr_q[27:24]) == i) begin
            chan_oh_s[i] = 1'b1;
         end else begin
            chan_oh_s[i] = 1'b0;
         end
      end
      targets_s = cmd_addr_q[31] ? ch_mask : (chan_oh_s & ch_mask);
      bad_s     = (!cmd_addr_q[31] && (int'(cmd_addr_q[27:24]) >= NCH)) ||
                  (targets_s == {NCH{1'b0}});
   end

   // Reply bookkeeping while waiting; a reply on the timeout cycle still counts
   always_comb begin
      replied_now_s = replied_q | (reply_dv & targets_q);
      all_replied_s = (replied_now_s == targets_q);
      timeout_s     = (timer_q == TIMEOUT);
   end

   // Strict-priority arbiter: only the highest pending source may issue
   always_comb begin
      trig_take_s  = 1'b0;
      abort_take_s = 1'b0;
      rdo_take_s   = 1'b0;
      fast_take_s  = 1'b0;
      slow_grant_s = 1'b0;
      if (trig_pend_q) begin
         trig_take_s = bcast_ok_s;
      end else if (abort_pend_q) begin
         abort_take_s = bcast_ok_s;
      end else if (rdo_pend_q) begin
         rdo_take_s = bcast_ok_s;
      end else if (fast_pend_q) begin
         fast_take_s = bcast_ok_s;
      end else if (slow_req_s) begin
         slow_grant_s = ((tx_busy & targets_q) == {NCH{1'b0}});
      end else begin
         slow_grant_s = 1'b0;
      end
   end

   // Slow FSM state register
   always_ff @(posedge gclk_40m) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Slow FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_dv) state_d = S_CHECK;
            else        state_d = S_IDLE;
         end
         S_CHECK: begin
            if (bad_s) state_d = S_ACK;
            else       state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (slow_grant_s) state_d = S_WAIT;
            else              state_d = S_ISSUE;
         end
         S_WAIT: begin
            if (all_replied_s || timeout_s) state_d = S_ACK;
            else                            state_d = S_WAIT;
         end
         S_ACK:     state_d = S_RELEASE;
         S_RELEASE: begin
            if (!cmd_dv) state_d = S_IDLE;
            else         state_d = S_RELEASE;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   // Slow FSM outputs; ack/err are registered on entry to ACK
   always_comb begin
      slow_req_s = (state_q == S_ISSUE);
      ack_set_s  = (state_d == S_ACK);
      err_set_s  = (state_q == S_CHECK) && (state_d == S_ACK);
      if ((state_q == S_WAIT) && !all_replied_s && timeout_s) begin
         to_set_s = targets_q & ~replied_now_s;
      end else begin
         to_set_s = {NCH{1'b0}};
      end
   end

   // Next values for pending events, the issued word and the slow datapath
   always_comb begin
      trig_pend_d  = (trig_pend_q & ~trig_take_s) | fee_trig;
      drop_s       = fee_trig & trig_pend_q & ~trig_take_s;
      abort_pend_d = (abort_pend_q & ~abort_take_s) | abortcmd;
      rdo_pend_d   = (rdo_pend_q & ~rdo_take_s & ~abortcmd) | rdocmd;
      fast_pend_d  = (fast_pend_q & ~fast_take_s) | fast_rise_s;
      fast_code_d  = fast_rise_s ? FastCmdCode : fast_code_q;
      fast_ack_d   = fast_take_s;

      tx_stb_d     = 1'b0;
      tx_sel_d     = {NCH{1'b0}};
      tx_type_d    = 3'd0;
      tx_payload_d = 64'd0;
      if (trig_take_s || abort_take_s || rdo_take_s || fast_take_s) begin
         tx_stb_d = any_ch_s;
         tx_sel_d = ch_mask;
         if (trig_take_s)       tx_type_d = TYPE_TRIG;
         else if (abort_take_s) tx_type_d = TYPE_ABORT;
         else if (rdo_take_s)   tx_type_d = TYPE_RDO;
         else                   tx_type_d = TYPE_FAST;
         if (fast_take_s) tx_payload_d = {56'd0, fast_code_q};
         else             tx_payload_d = 64'd0;
         if (!any_ch_s) begin
            tx_sel_d  = {NCH{1'b0}};
            tx_type_d = 3'd0;
         end else begin
            tx_sel_d  = ch_mask;
         end
      end else if (slow_grant_s) begin
         tx_stb_d     = 1'b1;
         tx_sel_d     = targets_q;
         tx_type_d    = TYPE_SLOW;
         tx_payload_d = {cmd_addr_q, cmd_data_q};
      end else begin
         tx_stb_d     = 1'b0;
      end

      cmd_addr_d = (state_q == S_IDLE) ? cmd_addr : cmd_addr_q;
      cmd_data_d = (state_q == S_IDLE) ? cmd_data : cmd_data_q;
      targets_d  = (state_q == S_CHECK) ? targets_s : targets_q;
      replied_d  = replied_q;
      timer_d    = timer_q;
      if (slow_grant_s) begin
         replied_d = {NCH{1'b0}};
         timer_d   = {{(TO_W-1){1'b0}}, 1'b1};
      end else if (state_q == S_WAIT) begin
         replied_d = replied_now_s;
         if (!timeout_s) timer_d = timer_q + {{(TO_W-1){1'b0}}, 1'b1};
         else            timer_d = timer_q;
      end else begin
         replied_d = replied_q;
      end

      to_err_d   = (err_clr ? {NCH{1'b0}} : to_err_q) | to_set_s;
      drop_cnt_d = err_clr ? 8'd0 : drop_cnt_q;
      if (drop_s && (drop_cnt_d != 8'd255)) drop_cnt_d = drop_cnt_d + 8'd1;
      else                                  drop_cnt_d = drop_cnt_d;
   end

   // Pending flags, slow datapath and registered outputs
   always_ff @(posedge gclk_40m) begin
      if (!reset_n) begin
         trig_pend_q  <= 1'b0;
         abort_pend_q <= 1'b0;
         rdo_pend_q   <= 1'b0;
         fast_pend_q  <= 1'b0;
         fast_code_q  <= 8'd0;
         fast_prev_q  <= 1'b0;
         cmd_addr_q   <= 32'd0;
         cmd_data_q   <= 32'd0;
         targets_q    <= {NCH{1'b0}};
         replied_q    <= {NCH{1'b0}};
         timer_q      <= {TO_W{1'b0}};
         tx_stb_q     <= 1'b0;
         tx_sel_q     <= {NCH{1'b0}};
         tx_type_q    <= 3'd0;
         tx_payload_q <= 64'd0;
         fast_ack_q   <= 1'b0;
         cmd_dv_ack_q <= 1'b0;
         cmd_err_q    <= 1'b0;
         to_err_q     <= {NCH{1'b0}};
         drop_cnt_q   <= 8'd0;
      end else begin
         trig_pend_q  <= trig_pend_d;
         abort_pend_q <= abort_pend_d;
         rdo_pend_q   <= rdo_pend_d;
         fast_pend_q  <= fast_pend_d;
         fast_code_q  <= fast_code_d;
         fast_prev_q  <= FastCmd;
         cmd_addr_q   <= cmd_addr_d;
         cmd_data_q   <= cmd_data_d;
         targets_q    <= targets_d;
         replied_q    <= replied_d;
         timer_q      <= timer_d;
         tx_stb_q     <= tx_stb_d;
         tx_sel_q     <= tx_sel_d;
         tx_type_q    <= tx_type_d;
         tx_payload_q <= tx_payload_d;
         fast_ack_q   <= fast_ack_d;
         cmd_dv_ack_q <= ack_set_s;
         cmd_err_q    <= err_set_s;
         to_err_q     <= to_err_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign tx_stb        = tx_stb_q;
   assign tx_sel        = tx_sel_q;
   assign tx_type       = tx_type_q;
   assign tx_payload    = tx_payload_q;
   assign FastCmdAck    = fast_ack_q;
   assign cmd_dv_ack    = cmd_dv_ack_q;
   assign cmd_err       = cmd_err_q;
   assign to_err        = to_err_q;
   assign trig_drop_cnt = drop_cnt_q;

`ifdef DTC_CMD_SCHED_STATS_EN
   logic [15:0] trig_cnt_q, slow_cnt_q;

   // Wrapping counts of issued trigger words and completed slow commands
   always_ff @(posedge gclk_40m) begin
      if (!reset_n) begin
         trig_cnt_q <= 16'd0;
         slow_cnt_q <= 16'd0;
      end else if (err_clr) begin
         trig_cnt_q <= 16'd0;
         slow_cnt_q <= 16'd0;
      end else begin
         trig_cnt_q <= trig_cnt_q + {15'd0, (trig_take_s & any_ch_s)};
         slow_cnt_q <= slow_cnt_q + {15'd0, ack_set_s};
      end
   end

   assign trig_cnt = trig_cnt_q;
   assign slow_cnt = slow_cnt_q;
`else
   assign trig_cnt = 16'd0;
   assign slow_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dtc_cmd_sched.sv
// Self-checking bench for dtc_cmd_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_dtc_cmd_sched;

   localparam int NCH    = 8;
   localparam int TO_CYC = 16;

   logic        gclk_40m = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  ch_mask = 8'hFF;
   logic        fee_trig = 1'b0, abortcmd = 1'b0, rdocmd = 1'b0;
   logic        FastCmd = 1'b0;
   logic [7:0]  FastCmdCode = 8'd0;
   logic        FastCmdAck;
   logic        cmd_dv = 1'b0;
   logic [31:0] cmd_addr = 32'd0, cmd_data = 32'd0;
   logic        cmd_dv_ack, cmd_err;
   logic [7:0]  tx_busy = 8'd0, reply_dv = 8'd0;
   logic        tx_stb;
   logic [7:0]  tx_sel;
   logic [2:0]  tx_type;
   logic [63:0] tx_payload;
   logic [7:0]  to_err, trig_drop_cnt;
   logic        err_clr = 1'b0;
   logic [15:0] trig_cnt, slow_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   dtc_cmd_sched #(.NCH(NCH), .TO_W(16), .TIMEOUT(16'(TO_CYC))) dut (
      .gclk_40m(gclk_40m), .reset_n(reset_n), .ch_mask(ch_mask),
      .fee_trig(fee_trig), .abortcmd(abortcmd), .rdocmd(rdocmd),
      .FastCmd(FastCmd), .FastCmdCode(FastCmdCode), .FastCmdAck(FastCmdAck),
      .cmd_dv(cmd_dv), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .cmd_dv_ack(cmd_dv_ack), .cmd_err(cmd_err),
      .tx_busy(tx_busy), .reply_dv(reply_dv),
      .tx_stb(tx_stb), .tx_sel(tx_sel), .tx_type(tx_type), .tx_payload(tx_payload),
      .to_err(to_err), .trig_drop_cnt(trig_drop_cnt), .err_clr(err_clr),
      .trig_cnt(trig_cnt), .slow_cnt(slow_cnt)
   );

   always #5 gclk_40m = ~gclk_40m;

   task automatic tick();
      @(posedge gclk_40m);
      #1;
   endtask

   task automatic wait_stb(input int max, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < max; k++) begin
         tick();
         if (tx_stb === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      n_checks++;
      if ({tx_stb, tx_sel, tx_type, tx_payload, FastCmdAck, cmd_dv_ack, cmd_err, to_err, trig_drop_cnt, trig_cnt, slow_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: stb=%0b sel=%h type=%0d ack=%0b err=%0b to_err=%h drop=%0d, required all zero",
                  tx_stb, tx_sel, tx_type, cmd_dv_ack, cmd_err, to_err, trig_drop_cnt);
      end
   endtask

   task automatic test_trig_abort();
      ch_mask = 8'hFF;
      fee_trig = 1'b1; abortcmd = 1'b1;
      tick();
      fee_trig = 1'b0; abortcmd = 1'b0;
      n_checks++;
      if (tx_stb !== 1'b0) begin n_fail++; $display("FAIL trig_early: stb=%0b required 0", tx_stb); end
      tick();
      n_checks++;
      if ({tx_stb, tx_type, tx_sel, tx_payload} !== {1'b1, 3'd1, 8'hFF, 64'd0}) begin
         n_fail++; $display("FAIL trig_word: stb=%0b type=%0d sel=%h pl=%h required 1/1/ff/0", tx_stb, tx_type, tx_sel, tx_payload);
      end
      tick();
      n_checks++;
      if ({tx_stb, tx_type, tx_sel} !== {1'b1, 3'd2, 8'hFF}) begin
         n_fail++; $display("FAIL abort_word: stb=%0b type=%0d sel=%h required 1/2/ff", tx_stb, tx_type, tx_sel);
      end
      tick();
      n_checks++;
      if (tx_stb !== 1'b0) begin n_fail++; $display("FAIL trig_abort_idle: stb=%0b required 0", tx_stb); end
   endtask

   task automatic test_busy_abort();
      int words_busy = 0, words_after = 0;
      logic [2:0] first_type = 3'd0;
      tx_busy = 8'h08;
      rdocmd = 1'b1;
      tick();
      rdocmd = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         abortcmd = (i == 5);
         tick();
         if (tx_stb === 1'b1) words_busy++;
      end
      abortcmd = 1'b0;
      tx_busy = 8'h00;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (tx_stb === 1'b1) begin
            if (words_after == 0) first_type = tx_type;
            words_after++;
         end
      end
      n_checks++;
      if (words_busy != 0) begin n_fail++; $display("FAIL busy_hold: words=%0d required 0", words_busy); end
      n_checks++;
      if (words_after != 1 || first_type !== 3'd2) begin
         n_fail++; $display("FAIL abort_kills_rdo: words=%0d type=%0d required 1 word type 2", words_after, first_type);
      end
   endtask

   task automatic test_slow_reply();
      bit ok;
      int acks = 0, words = 0;
      cmd_addr = 32'h0300_0010; cmd_data = 32'hA5A5_0001; cmd_dv = 1'b1;
      wait_stb(10, ok);
      n_checks++;
      if (!ok || {tx_type, tx_sel, tx_payload} !== {3'd5, 8'h08, 64'h0300_0010_A5A5_0001}) begin
         n_fail++; $display("FAIL slow_word: seen=%0b type=%0d sel=%h pl=%h required 5/08/0300_0010_a5a5_0001", ok, tx_type, tx_sel, tx_payload);
      end
      for (int k = 1; k < TO_CYC - 4; k++) begin
         tick();
         if (cmd_dv_ack === 1'b1) acks++;
      end
      reply_dv = 8'h08;
      tick();
      reply_dv = 8'h00;
      n_checks++;
      if (acks != 0 || {cmd_dv_ack, cmd_err, to_err} !== {1'b1, 1'b0, 8'h00}) begin
         n_fail++; $display("FAIL slow_reply_ack: early=%0d ack=%0b err=%0b to_err=%h required 0/1/0/00", acks, cmd_dv_ack, cmd_err, to_err);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         if (cmd_dv_ack === 1'b1) acks++;
         if (tx_stb === 1'b1) words++;
      end
      n_checks++;
      if (acks != 0 || words != 0) begin n_fail++; $display("FAIL held_dv_reexec: acks=%0d words=%0d required 0/0", acks, words); end
      cmd_dv = 1'b0;
      tick(); tick();
   endtask

   task automatic test_slow_timeout();
      bit ok;
      int got = -1;
      cmd_addr = 32'h8000_0044; cmd_data = $urandom; cmd_dv = 1'b1;
      wait_stb(10, ok);
      n_checks++;
      if (!ok || tx_sel !== 8'hFF || tx_type !== 3'd5) begin
         n_fail++; $display("FAIL bcast_word: seen=%0b sel=%h type=%0d required ff/5", ok, tx_sel, tx_type);
      end
      for (int k = 1; k <= 30; k++) begin
         reply_dv = (k == 3) ? 8'h01 : 8'h00;
         tick();
         if (cmd_dv_ack === 1'b1) begin got = k; break; end
      end
      reply_dv = 8'h00;
      n_checks++;
      if (got != TO_CYC || cmd_err !== 1'b0 || to_err !== 8'hFE) begin
         n_fail++; $display("FAIL timeout: ack_at=%0d err=%0b to_err=%h required %0d/0/fe", got, cmd_err, to_err, TO_CYC);
      end
      cmd_dv = 1'b0;
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_checks++;
      if (to_err !== 8'h00) begin n_fail++; $display("FAIL err_clr: to_err=%h required 00", to_err); end
   endtask

   task automatic bad_cmd(input logic [31:0] addr, input string name);
      int got = -1, words = 0;
      cmd_addr = addr; cmd_dv = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         if (tx_stb === 1'b1) words++;
         if (cmd_dv_ack === 1'b1) begin got = k; break; end
      end
      n_checks++;
      if (got < 0 || cmd_err !== 1'b1 || words != 0) begin
         n_fail++; $display("FAIL %s: ack_at=%0d err=%0b words=%0d required ack<=3 err=1 words=0", name, got, cmd_err, words);
      end
      cmd_dv = 1'b0;
      tick(); tick();
   endtask

   task automatic test_bad_target();
      bad_cmd(32'h0900_0000, "bad_channel");
      ch_mask = 8'hF7;
      bad_cmd(32'h0300_0000, "masked_channel");
      ch_mask = 8'hFF;
   endtask

   task automatic test_fast();
      logic [7:0] c1;
      c1 = 8'($urandom);
      FastCmd = 1'b1; FastCmdCode = c1;
      tick();
      FastCmdCode = c1 ^ 8'h5A;
      tick();
      n_checks++;
      if ({tx_stb, tx_type, tx_payload, FastCmdAck} !== {1'b1, 3'd4, {56'd0, c1}, 1'b1}) begin
         n_fail++; $display("FAIL fast_word: stb=%0b type=%0d pl=%h ack=%0b required 1/4/%h/1", tx_stb, tx_type, tx_payload, FastCmdAck, c1);
      end
      tick(); tick();
      n_checks++;
      if (tx_stb !== 1'b0 || FastCmdAck !== 1'b0) begin n_fail++; $display("FAIL fast_level: stb=%0b ack=%0b required 0/0", tx_stb, FastCmdAck); end
      FastCmd = 1'b0;
      ch_mask = 8'h00;
      tick();
      FastCmd = 1'b1; fee_trig = 1'b1;
      tick();
      FastCmd = 1'b0; fee_trig = 1'b0;
      tick(); tick();
      n_checks++;
      if (FastCmdAck !== 1'b1 || tx_stb !== 1'b0) begin
         n_fail++; $display("FAIL fast_nomask: ack=%0b stb=%0b required 1/0", FastCmdAck, tx_stb);
      end
      ch_mask = 8'hFF;
      tick(); tick();
      n_checks++;
      if (tx_stb !== 1'b0) begin n_fail++; $display("FAIL nomask_consumed: stb=%0b required 0", tx_stb); end
   endtask

   task automatic test_random();
      logic [7:0] model_to = 8'h00;
      for (int it = 0; it < 40; it++) begin
         int kind;
         logic [7:0] mask;
         kind = $urandom_range(0, 4);
         mask = 8'($urandom_range(1, 255));
         ch_mask = mask;
         if (kind <= 3) begin
            logic [7:0] code;
            code = 8'($urandom);
            if (kind == 0) fee_trig = 1'b1;
            else if (kind == 1) abortcmd = 1'b1;
            else if (kind == 2) rdocmd = 1'b1;
            else begin FastCmd = 1'b1; FastCmdCode = code; end
            tick();
            fee_trig = 1'b0; abortcmd = 1'b0; rdocmd = 1'b0; FastCmd = 1'b0;
            tick();
            n_checks++;
            if ({tx_stb, tx_type, tx_sel, tx_payload, FastCmdAck} !==
                {1'b1, 3'(kind + 1), mask, (kind == 3) ? {56'd0, code} : 64'd0, (kind == 3)}) begin
               n_fail++; $display("FAIL rand_bcast[%0d]: kind=%0d stb=%0b type=%0d sel=%h pl=%h fack=%0b mask=%h",
                                  it, kind, tx_stb, tx_type, tx_sel, tx_payload, FastCmdAck, mask);
            end
            tick();
         end else begin
            int ch, d, got, words;
            bit bc, ok;
            logic [7:0] tgt, rep;
            logic [31:0] addr, data;
            ch = $urandom_range(0, 15);
            bc = ($urandom_range(0, 7) == 0);
            addr = $urandom; addr[31] = bc; addr[27:24] = 4'(ch);
            data = $urandom;
            tgt = bc ? mask : ((ch < NCH) ? (mask & (8'd1 << ch)) : 8'd0);
            cmd_addr = addr; cmd_data = data; cmd_dv = 1'b1;
            got = -1; words = 0;
            if (tgt == 8'd0) begin
               for (int k = 1; k <= 3; k++) begin
                  tick();
                  if (tx_stb === 1'b1) words++;
                  if (cmd_dv_ack === 1'b1) begin got = k; break; end
               end
               n_checks++;
               if (got < 0 || cmd_err !== 1'b1 || words != 0) begin
                  n_fail++; $display("FAIL rand_bad[%0d]: addr=%h mask=%h ack_at=%0d err=%0b words=%0d", it, addr, mask, got, cmd_err, words);
               end
            end else begin
               d = $urandom_range(1, 24);
               rep = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
               wait_stb(10, ok);
               n_checks++;
               if (!ok || {tx_type, tx_sel, tx_payload} !== {3'd5, tgt, addr, data}) begin
                  n_fail++; $display("FAIL rand_slow_word[%0d]: seen=%0b type=%0d sel=%h pl=%h required sel %h pl %h%h",
                                     it, ok, tx_type, tx_sel, tx_payload, tgt, addr, data);
               end
               for (int k = 1; k <= 30; k++) begin
                  reply_dv = (k == d) ? rep : 8'h00;
                  tick();
                  if (cmd_dv_ack === 1'b1) begin got = k; break; end
               end
               reply_dv = 8'h00;
               if (d <= TO_CYC && (rep & tgt) == tgt) begin
                  d = d;
               end else begin
                  model_to = model_to | ((d <= TO_CYC) ? (tgt & ~rep) : tgt);
                  d = TO_CYC;
               end
               n_checks++;
               if (got != d || cmd_err !== 1'b0 || to_err !== model_to) begin
                  n_fail++; $display("FAIL rand_slow_ack[%0d]: ack_at=%0d err=%0b to_err=%h required %0d/0/%h", it, got, cmd_err, to_err, d, model_to);
               end
            end
            for (int h = $urandom_range(0, 3); h > 0; h--) tick();
            cmd_dv = 1'b0;
            tick(); tick();
            if ($urandom_range(0, 5) == 0) begin
               err_clr = 1'b1;
               tick();
               err_clr = 1'b0;
               model_to = 8'h00;
            end
         end
      end
      ch_mask = 8'hFF;
      n_checks++;
      if (to_err !== model_to) begin n_fail++; $display("FAIL rand_to_err_end: to_err=%h required %h", to_err, model_to); end
   endtask

   task automatic test_trig_merge_reset();
      bit ok;
      int words = 0, acks = 0;
      logic [2:0] t = 3'd0;
      tx_busy = 8'h01;
      for (int p = 0; p < 3; p++) begin
         fee_trig = 1'b1; tick();
         fee_trig = 1'b0; tick();
         if (tx_stb === 1'b1) words++;
      end
      n_checks++;
      if (trig_drop_cnt !== 8'd2 || words != 0) begin
         n_fail++; $display("FAIL trig_merge: drop=%0d words=%0d required 2/0", trig_drop_cnt, words);
      end
      tx_busy = 8'h00;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (tx_stb === 1'b1) begin words++; t = tx_type; end
      end
      n_checks++;
      if (words != 1 || t !== 3'd1) begin n_fail++; $display("FAIL trig_merged_word: words=%0d type=%0d required 1/1", words, t); end
      cmd_addr = 32'h0200_0000; cmd_dv = 1'b1;
      wait_stb(10, ok);
      for (int i = 0; i < 5; i++) tick();
      reset_n = 1'b0;
      tick();
      n_checks++;
      if (!ok || {tx_stb, tx_sel, tx_type, tx_payload, FastCmdAck, cmd_dv_ack, cmd_err, to_err, trig_drop_cnt} !== '0) begin
         n_fail++; $display("FAIL reset_mid_wait: issued=%0b stb=%0b ack=%0b drop=%0d to_err=%h required issued and all zero",
                            ok, tx_stb, cmd_dv_ack, trig_drop_cnt, to_err);
      end
      cmd_dv = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         reply_dv = (i == 3) ? 8'h04 : 8'h00;
         tick();
         if (cmd_dv_ack === 1'b1) acks++;
      end
      reply_dv = 8'h00;
      n_checks++;
      if (acks != 0) begin n_fail++; $display("FAIL dropped_cmd_ack: acks=%0d required 0", acks); end
   endtask

   initial begin
      #2;
      test_reset();
      test_trig_abort();
      test_busy_abort();
      test_slow_reply();
      test_slow_timeout();
      test_bad_target();
      test_fast();
      test_random();
      test_trig_merge_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
